// File: rtl/melody_pkg.sv
// melody_pkg: grade, score and judge FSM encodings shared by the lane judges
package melody_pkg;
  typedef enum logic [1:0] {
    GRADE_NONE    = 2'b00,
    GRADE_MISS    = 2'b01,
    GRADE_GOOD    = 2'b10,
    GRADE_PERFECT = 2'b11
  } grade_e;
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ARMED  = 2'b01,
    JUDGED = 2'b10
  } state_e;
  localparam logic [15:0] SCORE_PERFECT = 16'd3;
  localparam logic [15:0] SCORE_GOOD    = 16'd1;
endpackage

// File: rtl/key_sync_edge.sv
// key_sync_edge: three-flop synchronizer for a raw button with single-cycle rise detect
module key_sync_edge (
  input  logic clk,
  input  logic resetn,
  input  logic key,
  output logic key_rise
);
  logic [2:0] sync_q;
  // shift the asynchronous key through s1, s2, s3
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) sync_q <= '0;
    else sync_q <= {sync_q[1:0], key};
  assign key_rise = sync_q[1] & ~sync_q[2];
endmodule

// File: rtl/note_hit_judge.sv
// note_hit_judge: tracks one lane's note position and grades key presses against the hit line
module note_hit_judge
  import melody_pkg::*;
#(
  parameter logic [7:0] MIN_POS     = 8'd180,
  parameter logic [7:0] MAX_POS     = 8'd196,
  parameter logic [7:0] TARGET      = 8'd192,
  parameter logic [8:0] PERFECT_WIN = 9'd0,
  parameter logic [8:0] GOOD_WIN    = 9'd4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        map,
  input  logic        data_en,
  input  logic [7:0]  data,
  input  logic        key,
  output logic        hit_valid,
  output logic [1:0]  hit_grade,
  output logic [15:0] score,
  output logic [7:0]  combo
);
  if (GOOD_WIN < PERFECT_WIN || MIN_POS > MAX_POS) begin : g_bad_params
    $error("note_hit_judge: inconsistent window or position parameters");
  end
  logic key_rise;
  key_sync_edge u_key_sync (
    .clk      (clk),
    .resetn   (resetn),
    .key      (key),
    .key_rise (key_rise)
  );
  state_e      state_q, state_d;
  logic [7:0]  pos_q, pos_d;
  logic        hit_valid_q, hit_valid_d;
  grade_e      grade_q, grade_d;
  logic [15:0] score_q, score_d;
  logic [7:0]  combo_q, combo_d;
  logic        cap, wrap;
  logic [8:0]  diff;
  grade_e      key_grade;
  logic [15:0] inc;
  logic [16:0] sum;
  assign cap  = map && data_en;
  assign wrap = cap && (data < pos_q);
  assign diff = (pos_q >= TARGET) ? {1'b0, pos_q} - {1'b0, TARGET} : {1'b0, TARGET} - {1'b0, pos_q};
  assign key_grade = (diff <= PERFECT_WIN) ? GRADE_PERFECT : (diff <= GOOD_WIN) ? GRADE_GOOD : GRADE_MISS;
  // judge FSM: a key grades the pre-wrap note, a wrap with no key misses it
  always_comb begin
    state_d     = state_q;
    hit_valid_d = 1'b0;
    grade_d     = GRADE_NONE;
    case (state_q)
      IDLE:   if (cap) state_d = ARMED;
      ARMED:
        if (key_rise && map) begin
          hit_valid_d = 1'b1;
          grade_d     = key_grade;
          state_d     = wrap ? ARMED : JUDGED;
        end else if (wrap) begin
          hit_valid_d = 1'b1;
          grade_d     = GRADE_MISS;
        end
      JUDGED: if (wrap) state_d = ARMED;
      default: state_d = IDLE;
    endcase
  end
  // position capture plus saturating score and combo driven by the pulse being issued
  always_comb begin
    pos_d   = cap ? data : pos_q;
    inc     = (grade_d == GRADE_PERFECT) ? SCORE_PERFECT : (grade_d == GRADE_GOOD) ? SCORE_GOOD : 16'd0;
    sum     = {1'b0, score_q} + {1'b0, inc};
    score_d = !hit_valid_d ? score_q : sum[16] ? 16'hFFFF : sum[15:0];
    combo_d = !hit_valid_d ? combo_q : (grade_d == GRADE_MISS) ? 8'd0 : (combo_q == 8'hFF) ? combo_q : combo_q + 8'd1;
  end
  // state, position and registered judgement outputs
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state_q     <= IDLE;
      pos_q       <= MIN_POS;
      hit_valid_q <= 1'b0;
      grade_q     <= GRADE_NONE;
      score_q     <= '0;
      combo_q     <= '0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      hit_valid_q <= hit_valid_d;
      grade_q     <= grade_d;
      score_q     <= score_d;
      combo_q     <= combo_d;
    end
  assign hit_valid = hit_valid_q;
  assign hit_grade = grade_q;
  assign score     = score_q;
  assign combo     = combo_q;
endmodule

// File: tb/tb_note_hit_judge.sv
// tb_note_hit_judge: scoreboard bench driving directed note streams and key presses
module tb_note_hit_judge;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        map = 1'b0;
  logic        data_en = 1'b0;
  logic [7:0]  data = 8'd0;
  logic        key = 1'b0;
  logic        hit_valid;
  logic [1:0]  hit_grade;
  logic [15:0] score;
  logic [7:0]  combo;
  localparam logic [1:0] G_MISS = 2'b01, G_GOOD = 2'b10, G_PERF = 2'b11;
  typedef struct packed {
    logic [1:0]  g;
    logic [15:0] s;
    logic [7:0]  c;
  } exp_t;
  exp_t sb[$];
  exp_t cur;
  int checks = 0;
  int errors = 0;
  note_hit_judge dut (
    .clk       (clk),
    .resetn    (resetn),
    .map       (map),
    .data_en   (data_en),
    .data      (data),
    .key       (key),
    .hit_valid (hit_valid),
    .hit_grade (hit_grade),
    .score     (score),
    .combo     (combo)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic push(input logic [1:0] g, input logic [15:0] s, input logic [7:0] c);
    sb.push_back({g, s, c});
  endtask
  task automatic st(input logic [7:0] d, input logic e, input logic m, input logic k);
    @(negedge clk);
    data = d;
    data_en = e;
    map = m;
    key = k;
  endtask
  task automatic sweep();
    for (int p = 180; p <= 196; p += 4) st(8'(p), 1'b1, 1'b1, 1'b0);
  endtask
  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    map = 1'b0;
    data_en = 1'b0;
    key = 1'b0;
    data = 8'd0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_hit_valid", 32'(hit_valid), 32'd0);
    chk("rst_hit_grade", 32'(hit_grade), 32'd0);
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_combo", 32'(combo), 32'd0);
    resetn = 1'b1;
  endtask
  always @(negedge clk)
    if (resetn) begin
      if (hit_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: got grade %0d score %0d combo %0d with no pulse expected", hit_grade, score, combo);
        end else begin
          cur = sb.pop_front();
          chk("pulse_grade", 32'(hit_grade), 32'(cur.g));
          chk("pulse_score", 32'(score), 32'(cur.s));
          chk("pulse_combo", 32'(combo), 32'(cur.c));
        end
      end else chk("idle_grade", 32'(hit_grade), 32'd0);
    end
  initial begin
    do_reset();
    sweep();
    push(G_MISS, 16'd0, 8'd0);
    sweep();
    push(G_MISS, 16'd0, 8'd0);
    st(8'd180, 1'b1, 1'b1, 1'b0);
    st(8'd184, 1'b1, 1'b1, 1'b0);
    push(G_PERF, 16'd3, 8'd1);
    st(8'd188, 1'b1, 1'b1, 1'b1);
    st(8'd192, 1'b1, 1'b1, 1'b0);
    st(8'd196, 1'b1, 1'b1, 1'b0);
    st(8'd196, 1'b0, 1'b1, 1'b1);
    repeat (3) st(8'd196, 1'b0, 1'b1, 1'b0);
    chk("perfect_score", 32'(score), 32'd3);
    chk("perfect_combo", 32'(combo), 32'd1);
    do_reset();
    st(8'd180, 1'b1, 1'b1, 1'b0);
    push(G_GOOD, 16'd1, 8'd1);
    st(8'd184, 1'b1, 1'b1, 1'b1);
    st(8'd188, 1'b1, 1'b1, 1'b0);
    st(8'd192, 1'b1, 1'b1, 1'b0);
    st(8'd196, 1'b1, 1'b1, 1'b0);
    st(8'd180, 1'b1, 1'b1, 1'b0);
    st(8'd184, 1'b1, 1'b1, 1'b0);
    st(8'd188, 1'b1, 1'b1, 1'b0);
    push(G_GOOD, 16'd2, 8'd2);
    st(8'd192, 1'b1, 1'b1, 1'b1);
    st(8'd196, 1'b1, 1'b1, 1'b0);
    st(8'd196, 1'b0, 1'b1, 1'b0);
    push(G_MISS, 16'd2, 8'd0);
    st(8'd196, 1'b0, 1'b1, 1'b1);
    sweep();
    st(8'd180, 1'b1, 1'b1, 1'b0);
    st(8'd184, 1'b1, 1'b1, 1'b0);
    push(G_GOOD, 16'd3, 8'd1);
    st(8'd188, 1'b1, 1'b1, 1'b0);
    st(8'd192, 1'b1, 1'b1, 1'b1);
    st(8'd196, 1'b1, 1'b1, 1'b0);
    st(8'd180, 1'b1, 1'b1, 1'b0);
    st(8'd184, 1'b1, 1'b1, 1'b0);
    push(G_PERF, 16'd6, 8'd2);
    st(8'd188, 1'b1, 1'b1, 1'b1);
    st(8'd192, 1'b1, 1'b1, 1'b0);
    st(8'd196, 1'b1, 1'b1, 1'b0);
    st(8'd180, 1'b1, 1'b1, 1'b0);
    st(8'd184, 1'b1, 1'b1, 1'b0);
    st(8'd188, 1'b1, 1'b1, 1'b0);
    st(8'd192, 1'b1, 1'b1, 1'b0);
    st(8'd180, 1'b1, 1'b0, 1'b1);
    st(8'd180, 1'b1, 1'b0, 1'b0);
    st(8'd184, 1'b1, 1'b0, 1'b0);
    st(8'd188, 1'b1, 1'b0, 1'b0);
    push(G_PERF, 16'd9, 8'd3);
    st(8'd180, 1'b0, 1'b1, 1'b1);
    st(8'd180, 1'b0, 1'b1, 1'b0);
    st(8'd180, 1'b0, 1'b1, 1'b0);
    st(8'd180, 1'b0, 1'b1, 1'b0);
    chk("pause_score", 32'(score), 32'd9);
    chk("pause_combo", 32'(combo), 32'd3);
    st(8'd180, 1'b1, 1'b1, 1'b0);
    st(8'd184, 1'b1, 1'b1, 1'b0);
    st(8'd188, 1'b1, 1'b1, 1'b0);
    do_reset();
    st(8'd192, 1'b1, 1'b1, 1'b0);
    st(8'd196, 1'b1, 1'b1, 1'b0);
    repeat (3) st(8'd196, 1'b0, 1'b1, 1'b0);
    chk("resume_score", 32'(score), 32'd0);
    chk("resume_combo", 32'(combo), 32'd0);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
